n_bit_multicycle_adder_module: RTL and testbench
================================================

N_BIT_MULTICYCLE_ADDER_MODULE -- requirements
Module: n_bit_multicycle_adder_module

Interface
- REQ-001 Parameter WIDTH, default 16: operand/result width in bits.
- REQ-002 Parameter CHUNK, default 4: bits added per clock. WIDTH SHALL be a multiple of CHUNK. NCHUNK = WIDTH/CHUNK.
- REQ-003 clk  input  1  sole clock; all state changes on its rising edge.
- REQ-004 rst_n  input  1  reset, asynchronous, active-low.
- REQ-005 in_valid  input  1  operands/mode presented.
- REQ-006 in_ready  output  1  block can accept operands.
- REQ-007 a, b  input  WIDTH each  operands.
- REQ-008 cin  input  1  carry-in; used only when sub=0.
- REQ-009 sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- REQ-010 out_valid  output  1  result available.
- REQ-011 out_ready  input  1  consumer accepts result.
- REQ-012 sum  output  WIDTH  result.
- REQ-013 cout  output  1  carry out of MSB; in sub mode, 1 = no borrow.
- REQ-014 ovf  output  1  two's-complement signed overflow.

Function
- REQ-015 FSM states SHALL be IDLE, CALC and DONE.
- REQ-016 in_ready SHALL be 1 in IDLE only. out_valid SHALL be 1 in DONE only. Both are decoded from registered state.
- REQ-017 IDLE->CALC on an edge with in_valid=1 (accept edge).
  - Capture a, and b (inverted if sub=1).
  - Carry register <= sub ? 1 : cin.
  - Chunk index <= 0.
- REQ-018 CALC, each edge:
  - Add operand chunk [index*CHUNK +: CHUNK] with the carry register.
  - Write the result into the same sum slice.
  - Update the carry register; increment the index.
- REQ-019 On the CALC edge with index = NCHUNK-1, go to DONE.
  - Latch cout = final carry.
  - Latch ovf = carry-into-MSB XOR carry-out-of-MSB.
- REQ-020 out_valid SHALL rise exactly NCHUNK edges after the accept edge. With CHUNK=WIDTH the latency is 1.
- REQ-021 DONE->IDLE on an edge with out_ready=1. With out_ready=0, state, sum, cout and ovf SHALL hold indefinitely.
- REQ-022 Changes on a, b, cin, sub and in_valid outside the accept edge SHALL have no effect.
- REQ-023 After the DONE->IDLE transition, sum, cout and ovf SHALL retain their last values until the next result overwrites them.
- REQ-024 A new operand SHALL NOT be accepted on the same edge as a result handshake. Minimum issue interval is NCHUNK+2 cycles.
- REQ-025 Carry SHALL propagate across chunk boundaries with no loss, including all-ones operands.
- REQ-026 Results SHALL be bit-exact to (a + b + cin) mod 2^WIDTH, or (a - b) mod 2^WIDTH, for every parameter set.

Reset
- REQ-027 rst_n=0 SHALL asynchronously force:
  - state IDLE;
  - sum, cout, ovf, carry register and index to 0;
  - out_valid 0 and in_ready 1.
- REQ-028 Reset asserted in CALC or DONE SHALL abort the operation. No out_valid SHALL follow for the aborted operands.
- REQ-029 The first accept is possible on the first rising edge after rst_n deasserts.

Structure
- REQ-030 The shared package/include `adder_pkg` SHALL hold:
  - the FSM state encodings (IDLE=2'd0, CALC=2'd1, DONE=2'd2);
  - the default WIDTH and CHUNK constants.
- REQ-031 One combinational sub-module, n_bit_ripple_adder_module (parameter N=CHUNK).
  - Built from chained full_adder_gatelevel_module instances.
  - Exposes the carry into its MSB, for ovf.
- REQ-032 The top level SHALL contain only registers, the FSM, chunk muxing and one n_bit_ripple_adder_module instance. There SHALL be no behavioural '+' on full-width operands.

Verification (WIDTH=16, CHUNK=4 unless stated)
- REQ-033 a=0x1234, b=0x1111, cin=0, sub=0 -> sum=0x2345, cout=0, ovf=0. out_valid rises 4 edges after accept.
- REQ-034 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0 (full ripple). a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- REQ-035 sub=1 cases:
  - a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0, ovf=0.
  - a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
  - cin=1 is ignored.
- REQ-036 Backpressure: out_ready=0 for 5 cycles with in_valid=1 and changing operands -> sum, cout, ovf and out_valid stable; in_ready=0; the next accept occurs only after the out handshake.
- REQ-037 rst_n pulsed low 2 cycles into CALC -> outputs 0 immediately, in_ready=1; no out_valid for the aborted job. The next job a=0x0001, b=0x0001 -> sum=0x0002.
- REQ-038 Parameter sweep, (WIDTH,CHUNK) in {(8,1),(16,16),(32,8)}, 1000 random operand/mode pairs each -> every result matches the reference model, with latency NCHUNK.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants for the chunked multicycle adder: FSM encodings and default sizing.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

endpackage

// File: rtl/full_adder_gatelevel_module.sv
// One-bit full adder built from gate primitives; the leaf cell of the ripple chain.
module full_adder_gatelevel_module (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;
    logic g;
    logic t;

    xor u_x1 (p, a, b);
    xor u_x2 (s, p, cin);
    and u_a1 (g, a, b);
    and u_a2 (t, p, cin);
    or  u_o1 (cout, g, t);

endmodule

// File: rtl/n_bit_ripple_adder_module.sv
// Combinational N-bit ripple-carry adder; also exposes the carry into the MSB for overflow.
module n_bit_ripple_adder_module
    import adder_pkg::*;
#(
    parameter int N = DEFAULT_CHUNK
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout,
    output logic         c_msb
);

    logic [N:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_fa
        full_adder_gatelevel_module u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    assign cout  = c[N];
    assign c_msb = c[N-1];

endmodule

// File: rtl/n_bit_multicycle_adder_module.sv
// Multicycle adder/subtractor: processes CHUNK bits per clock through one shared ripple adder.
//   state | meaning
//   IDLE  | ready for operands; previous result held on sum/cout/ovf
//   CALC  | adding chunk idx, carry threaded through the carry register
//   DONE  | result valid, waiting for out_ready
module n_bit_multicycle_adder_module
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    adder_state_t    state;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic            carry;
    logic [IDXW-1:0] idx;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;
    logic             c_msb;

    always_comb begin
        a_chunk = op_a[int'(idx)*CHUNK +: CHUNK];
        b_chunk = op_b[int'(idx)*CHUNK +: CHUNK];
    end

    n_bit_ripple_adder_module #(.N(CHUNK)) u_ripple (
        .a     (a_chunk),
        .b     (b_chunk),
        .cin   (carry),
        .s     (s_chunk),
        .cout  (c_out),
        .c_msb (c_msb)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // b is stored pre-inverted for subtraction so CALC never looks at the mode again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        idx   <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    sum[int'(idx)*CHUNK +: CHUNK] <= s_chunk;
                    carry <= c_out;
                    idx   <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout  <= c_out;
                        ovf   <= c_msb ^ c_out;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_n_bit_multicycle_adder_module.sv
// Self-checking bench: directed corner cases, backpressure, reset abort and a parameter sweep.
module tb_n_bit_multicycle_adder_module;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, sub, cout, ovf;

    n_bit_multicycle_adder_module u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
    );

    logic        sw_in_valid, sw_out_ready, sw_cin, sw_sub;
    logic [31:0] sw_a, sw_b;
    logic        ir1, ir2, ir3, ov1, ov2, ov3, co1, co2, co3, of1, of2, of3;
    logic [7:0]  sum1;
    logic [15:0] sum2;
    logic [31:0] sum3;

    n_bit_multicycle_adder_module #(.WIDTH(8), .CHUNK(1)) u_w8c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir1),
        .a(sw_a[7:0]), .b(sw_b[7:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(ov1),
        .out_ready(sw_out_ready), .sum(sum1), .cout(co1), .ovf(of1)
    );
    n_bit_multicycle_adder_module #(.WIDTH(16), .CHUNK(16)) u_w16c16 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir2),
        .a(sw_a[15:0]), .b(sw_b[15:0]), .cin(sw_cin), .sub(sw_sub), .out_valid(ov2),
        .out_ready(sw_out_ready), .sum(sum2), .cout(co2), .ovf(of2)
    );
    n_bit_multicycle_adder_module #(.WIDTH(32), .CHUNK(8)) u_w32c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_in_valid), .in_ready(ir3),
        .a(sw_a), .b(sw_b), .cin(sw_cin), .sub(sw_sub), .out_valid(ov3),
        .out_ready(sw_out_ready), .sum(sum3), .cout(co3), .ovf(of3)
    );

    // Reference: plain wide arithmetic, returns {ovf, cout, sum[31:0]}.
    function automatic logic [33:0] ref_model(input int w, input logic [31:0] x,
                                              input logic [31:0] y, input logic ci,
                                              input logic s);
        logic [33:0] m, xa, yb, full;
        logic [31:0] rs;
        logic        co, sa, sb, ss, ov;
        m    = (34'd1 << w) - 34'd1;
        xa   = {2'b00, x} & m;
        yb   = s ? (~{2'b00, y}) & m : {2'b00, y} & m;
        full = xa + yb + ((s || ci) ? 34'd1 : 34'd0);
        rs   = full[31:0] & m[31:0];
        co   = full[w];
        sa   = x[w-1];
        sb   = y[w-1];
        ss   = rs[w-1];
        ov   = s ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
        return {ov, co, rs};
    endfunction

    // Issue one operation on the 16/4 instance with out_ready=1; called at a negedge in IDLE.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb,
                          input logic vc, input logic vs, input string name);
        logic [33:0] exp;
        int lat;
        exp = ref_model(16, {16'h0, va}, {16'h0, vb}, vc, vs);
        a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4) begin
            errors++;
            $display("FAIL %s latency: got %0d expected 4", name, lat);
        end
        checks++;
        if ({ovf, cout, sum} !== {exp[33], exp[32], exp[15:0]}) begin
            errors++;
            $display("FAIL %s result: got sum=%h cout=%b ovf=%b expected sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, exp[15:0], exp[32], exp[33]);
        end
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, ovf, cout, sum} !== {1'b1, 1'b0, exp[33], exp[32], exp[15:0]}) begin
            errors++;
            $display("FAIL %s retain: got rdy=%b vld=%b sum=%h cout=%b ovf=%b expected rdy=1 vld=0 sum=%h cout=%b ovf=%b",
                     name, in_ready, out_valid, sum, cout, ovf, exp[15:0], exp[32], exp[33]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
        sw_in_valid = 1'b0; sw_out_ready = 1'b1; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
        #12;
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b vld=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run_op(16'h1234, 16'h1111, 1'b0, 1'b0, "first_accept");
    endtask

    task automatic test_directed();
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, "full_ripple");
        run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, "pos_ovf");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "all_ones_cin");
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, "sub_borrow");
        run_op(16'h8000, 16'h0001, 1'b0, 1'b1, "sub_ovf");
        run_op(16'h0005, 16'h0007, 1'b1, 1'b1, "sub_cin_ignored");
    endtask

    task automatic test_backpressure();
        logic [33:0] exp;
        int lat;
        exp = ref_model(16, 32'h4000, 32'h4000, 1'b0, 1'b0);
        a = 16'h4000; b = 16'h4000; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, ovf, cout, sum} !== {1'b1, 1'b0, exp[33], exp[32], exp[15:0]}) begin
                errors++;
                $display("FAIL backpressure_hold%0d: got vld=%b rdy=%b sum=%h cout=%b ovf=%b expected 1 0 %h %b %b",
                         i, out_valid, in_ready, sum, cout, ovf, exp[15:0], exp[32], exp[33]);
            end
        end
        a = 16'h0003; b = 16'h0004; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL handshake_no_accept: got rdy=%b vld=%b expected rdy=1 vld=0", in_ready, out_valid);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL accept_after_handshake: got rdy=%b expected 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat !== 4 || sum !== 16'h0007) begin
            errors++;
            $display("FAIL post_backpressure_job: got lat=%0d sum=%h expected lat=4 sum=0007", lat, sum);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        int seen;
        a = 16'h1357; b = 16'h2468; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, sum, cout, ovf} !== {1'b1, 1'b0, 16'h0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL abort_async_clear: got rdy=%b vld=%b sum=%h cout=%b ovf=%b expected 1 0 0000 0 0",
                     in_ready, out_valid, sum, cout, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || in_ready !== 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_result: got %0d cycles with vld/busy expected 0", seen);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, "after_abort");
    endtask

    task automatic test_random();
        for (int n = 0; n < 200; n++)
            run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), "random16c4");
    endtask

    task automatic test_sweep();
        int          wd[3] = '{8, 16, 32};
        int          nc[3] = '{8, 1, 4};
        logic [33:0] exp[3];
        logic [33:0] act[3];
        logic [33:0] bad_act[3];
        logic [2:0]  ov_v, rdy_v;
        bit          bad[3];
        for (int n = 0; n < 1000; n++) begin
            sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
            for (int k = 0; k < 3; k++) begin
                exp[k] = ref_model(wd[k], sw_a, sw_b, sw_cin, sw_sub);
                bad[k] = 1'b0;
                bad_act[k] = '0;
            end
            rdy_v = {ir3, ir2, ir1};
            sw_in_valid = 1'b1;
            @(negedge clk);
            sw_in_valid = 1'b0;
            sw_a = $urandom; sw_b = $urandom; sw_cin = 1'($urandom); sw_sub = 1'($urandom);
            for (int j = 1; j <= 9; j++) begin
                @(negedge clk);
                ov_v   = {ov3, ov2, ov1};
                act[0] = {of1, co1, 24'h0, sum1};
                act[1] = {of2, co2, 16'h0, sum2};
                act[2] = {of3, co3, sum3};
                for (int k = 0; k < 3; k++) begin
                    if (ov_v[k] !== ((j == nc[k]) ? 1'b1 : 1'b0)) begin
                        bad[k] = 1'b1;
                        bad_act[k] = act[k];
                    end
                    if (j == nc[k] && act[k] !== exp[k]) begin
                        bad[k] = 1'b1;
                        bad_act[k] = act[k];
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (bad[k] || rdy_v[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL sweep w%0d n%0d: got {ovf,cout,sum}=%h rdy=%b expected %h with latency %0d",
                             wd[k], n, bad_act[k], rdy_v[k], exp[k], nc[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
